// File: rtl/fp_alu_sched.sv
// fp_alu_sched: round-robin scheduler sharing one multicycle fp_alu between two requesters (optional FP_ALU_SCHED_STATS_EN grant counters)
module fp_alu_sched #(
  parameter int ALU_LAT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [1:0]       req1_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_opcode,
  output logic             alu_add_sub,
  input  logic [31:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
`ifdef FP_ALU_SCHED_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
`endif
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LOAD = 4'(ALU_LAT - 1);
  logic [1:0] state;
  logic       last_grant;
  logic       id_q;
  logic [3:0] cnt;
  logic       grant0, grant1, sel;
  logic [1:0] op;
  // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    sel = grant1;
    op = sel ? req1_op : req0_op;
    busy = state != IDLE;
  end
  // Issue, hold operands for ALU_LAT cycles, capture result, then wait for the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      id_q <= 1'b0;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_opcode <= '0;
      alu_add_sub <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
    end else if (state == IDLE) begin
      if (req0_ready || req1_ready) begin
        alu_a <= sel ? req1_a : req0_a;
        alu_b <= sel ? req1_b : req0_b;
        alu_opcode <= op[1] ? (op[0] ? 2'b10 : 2'b01) : 2'b00;
        alu_add_sub <= op == 2'b01;
        id_q <= sel;
        last_grant <= sel;
        cnt <= LOAD;
        state <= WAIT;
      end
    end else if (state == WAIT) begin
      if (cnt == '0) begin
        rsp_result <= alu_result;
        rsp_valid <= 1'b1;
        rsp_id <= id_q;
        state <= RESP;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      state <= IDLE;
    end
  end
`ifdef FP_ALU_SCHED_STATS_EN
  // Per-requester accept counters, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif
endmodule
